// File: rtl/lane_tx_scheduler.sv
// Round-robin scheduler for the four PHY TX lanes. Each cycle grants at most
// one valid lane (combinational ready_N), registers the popped byte onto a
// single output stream tagged with its source lane, and bounds per-lane bursts
// so a busy lane cannot starve the others. Idle cycles carry IDLE_SYM.
module lane_tx_scheduler #(
    parameter int                 DATA_W    = 8,
    parameter int                 MAX_BURST = 4,
    parameter logic [DATA_W-1:0]  IDLE_SYM  = 8'hBC
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    input  logic              valid_3,
    output logic              ready_0,
    output logic              ready_1,
    output logic              ready_2,
    output logic              ready_3,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Burst counter is 4 bits wide, enough for MAX_BURST up to 15.
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t            state;
    state_t            state_next;
    logic [1:0]        owner;
    logic [3:0]        burst_cnt;
    logic [3:0]        burst_next;
    logic [3:0]        valid_vec;
    logic              others_valid;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] grant_data;

    assign valid_vec = {valid_3, valid_2, valid_1, valid_0};

    // Grant decision: keep the owner while its burst budget lasts (or nobody
    // else is waiting), otherwise search owner+1, owner+2, owner+3, owner.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid  = 1'b0;
        grant_idx    = owner;
        others_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            others_valid = others_valid | valid_vec[owner + 2'(i)];
        end
        // Gated by reset so the handshake is dead the instant reset asserts.
        if (enable && !reset) begin
            if (valid_vec[owner] && ((burst_cnt < MAX_CNT) || !others_valid)) begin
                grant_valid = 1'b1;
                grant_idx   = owner;
            end else begin
                // Walk from lowest to highest priority; the last hit wins,
                // which leaves the nearest lane after the owner granted.
                for (int i = 4; i >= 1; i--) begin
                    if (valid_vec[owner + 2'(i)]) begin
                        grant_valid = 1'b1;
                        grant_idx   = owner + 2'(i);
                    end
                end
            end
        end
    end

    // One-hot ready outputs straight from the grant; never depend on any
    // downstream ready, so there is no combinational loop through this block.
    always_comb begin
        ready_0 = grant_valid && (grant_idx == 2'd0);
        ready_1 = grant_valid && (grant_idx == 2'd1);
        ready_2 = grant_valid && (grant_idx == 2'd2);
        ready_3 = grant_valid && (grant_idx == 2'd3);
    end

    // Select the granted lane's byte for registering.
    always_comb begin
        grant_data = data_0;
        case (grant_idx)
            2'd0:    grant_data = data_0;
            2'd1:    grant_data = data_1;
            2'd2:    grant_data = data_2;
            default: grant_data = data_3;
        endcase
    end

    // Next state and burst count: a burst continues only across back-to-back
    // grants to the same owner; the counter saturates instead of wrapping.
    always_comb begin
        state_next = grant_valid ? BUSY : IDLE;
        burst_next = 4'd0;
        if (grant_valid) begin
            if ((grant_idx == owner) && (state == BUSY)) begin
                burst_next = (burst_cnt < MAX_CNT) ? burst_cnt + 4'd1 : burst_cnt;
            end else begin
                burst_next = 4'd1;
            end
        end
    end

    // State register and registered output stream.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            // Owner starts at 3 so lane 0 is first in the search order.
            state     <= IDLE;
            owner     <= 2'd3;
            burst_cnt <= 4'd0;
            data_out  <= IDLE_SYM;
            valid_out <= 1'b0;
            lane_sel  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_next;
            burst_cnt <= burst_next;
            if (grant_valid) begin
                owner     <= grant_idx;
                data_out  <= grant_data;
                valid_out <= 1'b1;
                lane_sel  <= grant_idx;
            end else begin
                // Owner and lane_sel hold so rotation resumes where it left off.
                data_out  <= IDLE_SYM;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Directed bench for lane_tx_scheduler: reset mid-burst, single-lane streaming,
// idle fill, owner drop, full rotation and enable gating.
module tb_lane_tx_scheduler;

    localparam int         DATA_W    = 8;
    localparam int         MAX_BURST = 4;
    localparam logic [7:0] IDLE_SYM  = 8'hBC;

    logic              clk_4f = 1'b0;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
    logic              valid_0, valid_1, valid_2, valid_3;
    logic              ready_0, ready_1, ready_2, ready_3;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        lane_sel;
    logic [3:0]        ready_vec;

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt [4];

    assign ready_vec = {ready_3, ready_2, ready_1, ready_0};

    lane_tx_scheduler #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .IDLE_SYM  (IDLE_SYM)
    ) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .enable    (enable),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .valid_2   (valid_2),
        .valid_3   (valid_3),
        .ready_0   (ready_0),
        .ready_1   (ready_1),
        .ready_2   (ready_2),
        .ready_3   (ready_3),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_sel  (lane_sel)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic [1:0] l);
        check({tag, ".data_out"},  32'(data_out),  32'(d));
        check({tag, ".valid_out"}, 32'(valid_out), 32'(v));
        check({tag, ".lane_sel"},  32'(lane_sel),  32'(l));
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {valid_3, valid_2, valid_1, valid_0} = v;
    endtask

    initial begin
        logic [1:0] exp_lane;

        // ---------------- reset state ----------------
        reset  = 1'b1;
        enable = 1'b1;
        data_0 = 8'hA0; data_1 = 8'hA1; data_2 = 8'hA2; data_3 = 8'hA3;
        set_valid(4'b0000);
        #3;
        check_out("reset", IDLE_SYM, 1'b0, 2'd0);
        set_valid(4'b0010);
        #1;
        check("reset.ready", 32'(ready_vec), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset mid-burst ----------------
        #1;
        check("rst_burst.ready0", 32'(ready_vec), 32'b0010);
        tick();
        check_out("rst_burst.b0", 8'hA1, 1'b1, 2'd1);
        tick();
        check_out("rst_burst.b1", 8'hA1, 1'b1, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst_async", IDLE_SYM, 1'b0, 2'd0);
        check("rst_async.ready", 32'(ready_vec), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        set_valid(4'b0110);
        #1;
        check("rst_release.ready", 32'(ready_vec), 32'b0010);
        tick();
        check_out("rst_release.out", 8'hA1, 1'b1, 2'd1);
        set_valid(4'b0000);
        tick();
        check_out("rst_release.idle", IDLE_SYM, 1'b0, 2'd1);

        // ---------------- single lane, saturating burst ----------------
        for (int i = 0; i < 10; i++) begin
            data_2 = 8'(8'h10 + i);
            set_valid(4'b0100);
            #1;
            check($sformatf("single.ready[%0d]", i), 32'(ready_vec), 32'b0100);
            tick();
            check_out($sformatf("single.out[%0d]", i), 8'(8'h10 + i), 1'b1, 2'd2);
        end
        set_valid(4'b0000);
        data_2 = 8'hA2;

        // ---------------- idle fill ----------------
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("idle.out[%0d]", i), IDLE_SYM, 1'b0, 2'd2);
            check($sformatf("idle.ready[%0d]", i), 32'(ready_vec), 32'h0);
        end
        // Kept owner is 2: lane 3 comes before lane 1.
        set_valid(4'b1010);
        #1;
        check("idle.next_ready", 32'(ready_vec), 32'b1000);
        tick();
        check_out("idle.next_out", 8'hA3, 1'b1, 2'd3);
        set_valid(4'b0001);
        #1;
        check("wrap.ready", 32'(ready_vec), 32'b0001);
        tick();
        check_out("wrap.out", 8'hA0, 1'b1, 2'd0);
        set_valid(4'b0000);
        tick();

        // ---------------- owner drop (owner 0, lanes 0 and 3 valid) ----------------
        set_valid(4'b1001);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("drop.ready0[%0d]", i), 32'(ready_vec), 32'b0001);
            tick();
            check_out($sformatf("drop.out0[%0d]", i), 8'hA0, 1'b1, 2'd0);
        end
        set_valid(4'b1000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("drop.ready3[%0d]", i), 32'(ready_vec), 32'b1000);
            tick();
            check_out($sformatf("drop.out3[%0d]", i), 8'hA3, 1'b1, 2'd3);
        end
        // Make lane 0 the owner again, then go idle.
        set_valid(4'b0001);
        tick();
        set_valid(4'b0000);
        tick();

        // ---------------- all lanes valid: rotation ----------------
        for (int n = 0; n < 4; n++) ready_cnt[n] = 0;
        set_valid(4'b1111);
        for (int i = 0; i < 16; i++) begin
            exp_lane = 2'(i / MAX_BURST);
            #1;
            check($sformatf("rr.ready[%0d]", i), 32'(ready_vec), 32'(4'b0001 << exp_lane));
            for (int n = 0; n < 4; n++) if (ready_vec[n]) ready_cnt[n]++;
            tick();
            check_out($sformatf("rr.out[%0d]", i), 8'(8'hA0 + exp_lane), 1'b1, exp_lane);
        end
        for (int n = 0; n < 4; n++)
            check($sformatf("rr.pulses[%0d]", n), 32'(ready_cnt[n]), 32'(MAX_BURST));

        // Rotation wraps to lane 0, then lane 1 starts its burst.
        for (int i = 0; i < 6; i++) begin
            exp_lane = (i < 4) ? 2'd0 : 2'd1;
            #1;
            check($sformatf("rr2.ready[%0d]", i), 32'(ready_vec), 32'(4'b0001 << exp_lane));
            tick();
            check_out($sformatf("rr2.out[%0d]", i), 8'(8'hA0 + exp_lane), 1'b1, exp_lane);
        end

        // ---------------- enable drop mid-burst of lane 1 ----------------
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("en.ready[%0d]", i), 32'(ready_vec), 32'h0);
            tick();
            check_out($sformatf("en.out[%0d]", i), IDLE_SYM, 1'b0, 2'd1);
        end
        enable = 1'b1;
        // Lane 1 gets a fresh burst of MAX_BURST, then lane 2.
        for (int i = 0; i < 5; i++) begin
            exp_lane = (i < 4) ? 2'd1 : 2'd2;
            #1;
            check($sformatf("en_resume.ready[%0d]", i), 32'(ready_vec), 32'(4'b0001 << exp_lane));
            tick();
            check_out($sformatf("en_resume.out[%0d]", i), 8'(8'hA0 + exp_lane), 1'b1, exp_lane);
        end
        set_valid(4'b0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
